// File: rtl/hw_counter_unit.sv
// rtl/hw_counter_unit.sv - branch-event performance counters with run control, snapshot shadows and a registered read port
module hw_counter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             snap,
  input  logic             ev_cond,
  input  logic             ev_uncond,
  input  logic             ev_bp_ok,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int NCNT = 5;
  localparam int C_CYCLE  = 0;
  localparam int C_COND   = 1;
  localparam int C_UNCOND = 2;
  localparam int C_BP_OK  = 3;
  localparam int C_BP_BAD = 4;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] live   [NCNT];
  logic [WIDTH-1:0] shadow [NCNT];
  logic [NCNT-1:0]  ovf;
  logic [NCNT-1:0]  inc;
  logic [WIDTH-1:0] rd_mux;

  // stop has priority over start; running tracks the next state so it equals (state==RUN)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= HALT;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    inc = '0;
    if (state == RUN) begin
      inc[C_CYCLE]  = 1'b1;
      inc[C_COND]   = ev_cond;
      inc[C_UNCOND] = ev_uncond;
      inc[C_BP_OK]  = ev_cond & ev_bp_ok;
      inc[C_BP_BAD] = ev_cond & ~ev_bp_ok;
    end
  end

  // Shadows sample the registered live values, so snap sees pre-increment and pre-clear counts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCNT; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (snap) begin
          shadow[i] <= live[i];
        end
        if (clear) begin
          live[i] <= '0;
          ovf[i]  <= 1'b0;
        end else if (inc[i]) begin
          if (live[i] == CNT_MAX) begin
            ovf[i] <= 1'b1;
          end else begin
            live[i] <= live[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      3'd0:    rd_mux = shadow[C_CYCLE];
      3'd1:    rd_mux = shadow[C_COND];
      3'd2:    rd_mux = shadow[C_UNCOND];
      3'd3:    rd_mux = shadow[C_BP_OK];
      3'd4:    rd_mux = shadow[C_BP_BAD];
      3'd5:    rd_mux = WIDTH'(ovf);
      3'd6:    rd_mux = WIDTH'(state);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_hw_counter_unit.sv
// tb/tb_hw_counter_unit.sv - directed self-checking bench for hw_counter_unit
module tb_hw_counter_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start, stop, clear, snap;
  logic         ev_cond, ev_uncond, ev_bp_ok;
  logic         rd_req;
  logic [2:0]   rd_addr;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         running;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hw_counter_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .snap     (snap),
    .ev_cond  (ev_cond),
    .ev_uncond(ev_uncond),
    .ev_bp_ok (ev_bp_ok),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .running  (running)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rstn = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic run_cycle(input logic c, input logic u, input logic ok, input logic st);
    ev_cond = c; ev_uncond = u; ev_bp_ok = ok; stop = st;
    tick;
    ev_cond = 1'b0; ev_uncond = 1'b0; ev_bp_ok = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic pulse_snap;
    snap = 1'b1;
    tick;
    snap = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic v, output logic [W-1:0] d);
    rd_req = 1'b1; rd_addr = a;
    tick;
    rd_req = 1'b0;
    v = rd_valid; d = rd_data;
  endtask

  task automatic test_reset;
    logic v; logic [W-1:0] d;
    apply_reset;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    do_read(3'd6, v, d);
    n_checks++; if (v !== 1'b1 || d !== 4'd0) begin n_fail++; $display("FAIL reset_state: got v=%b d=%0d expected v=1 d=0", v, d); end
    do_read(3'd0, v, d);
    n_checks++; if (v !== 1'b1 || d !== 4'd0) begin n_fail++; $display("FAIL reset_cycle: got v=%b d=%0d expected v=1 d=0", v, d); end
  endtask

  task automatic test_basic_counting;
    logic v; logic [W-1:0] d;
    logic [9:0] cv  = 10'b0001010101;
    logic [9:0] okv = 10'b0000010101;
    logic [9:0] uv  = 10'b0000001010;
    int exp_v[5] = '{10, 4, 2, 3, 1};
    apply_reset;
    pulse_start;
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %b expected 1", running); end
    for (int k = 0; k < 10; k++) run_cycle(cv[k], uv[k], okv[k], k == 9);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL basic_halted: got %b expected 0", running); end
    pulse_snap;
    for (int a = 0; a < 5; a++) begin
      do_read(3'(a), v, d);
      n_checks++;
      if (v !== 1'b1 || d !== 4'(exp_v[a])) begin
        n_fail++; $display("FAIL basic_read%0d: got v=%b d=%0d expected v=1 d=%0d", a, v, d, exp_v[a]);
      end
    end
  endtask

  task automatic test_gating;
    logic v; logic [W-1:0] d;
    int exp_v[5] = '{10, 4, 2, 3, 1};
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    pulse_snap;
    for (int a = 0; a < 5; a++) begin
      do_read(3'(a), v, d);
      n_checks++;
      if (d !== 4'(exp_v[a])) begin n_fail++; $display("FAIL halt_gate%0d: got %0d expected %0d", a, d, exp_v[a]); end
    end
    do_read(3'd6, v, d);
    n_checks++; if (d !== 4'd2) begin n_fail++; $display("FAIL halt_state: got %0d expected 2", d); end
    apply_reset;
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    pulse_snap;
    for (int a = 0; a < 5; a++) begin
      do_read(3'(a), v, d);
      n_checks++;
      if (d !== 4'd0) begin n_fail++; $display("FAIL idle_gate%0d: got %0d expected 0", a, d); end
    end
    do_read(3'd6, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL idle_state: got %0d expected 0", d); end
  endtask

  task automatic test_saturation;
    logic v; logic [W-1:0] d;
    apply_reset;
    pulse_start;
    for (int k = 0; k < 20; k++) run_cycle(1'b0, 1'b0, 1'b0, k == 19);
    pulse_snap;
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd15) begin n_fail++; $display("FAIL sat_cycle: got %0d expected 15", d); end
    do_read(3'd5, v, d);
    n_checks++; if (d !== 4'b0001) begin n_fail++; $display("FAIL sat_ovf: got %b expected 0001", d); end
    pulse_clear;
    pulse_snap;
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL sat_clear_cycle: got %0d expected 0", d); end
    do_read(3'd5, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL sat_clear_ovf: got %b expected 0000", d); end
  endtask

  task automatic test_simultaneous;
    logic v; logic [W-1:0] d;
    pulse_start;
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ev_cond = 1'b1; clear = 1'b1;
    tick;
    ev_cond = 1'b0; clear = 1'b0;
    snap = 1'b1; stop = 1'b1;
    tick;
    snap = 1'b0; stop = 1'b0;
    do_read(3'd1, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL clear_vs_cond: got %0d expected 0", d); end
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL clear_vs_cycle: got %0d expected 0", d); end

    pulse_clear;
    pulse_start;
    for (int k = 0; k < 7; k++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ev_cond = 1'b1; snap = 1'b1;
    tick;
    ev_cond = 1'b0; snap = 1'b0;
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    do_read(3'd1, v, d);
    n_checks++; if (d !== 4'd7) begin n_fail++; $display("FAIL snap_vs_cond: got %0d expected 7", d); end
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd7) begin n_fail++; $display("FAIL snap_vs_cycle: got %0d expected 7", d); end
    snap = 1'b1; clear = 1'b1;
    tick;
    snap = 1'b0; clear = 1'b0;
    do_read(3'd1, v, d);
    n_checks++; if (d !== 4'd8) begin n_fail++; $display("FAIL snapclr_cond: got %0d expected 8", d); end
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd9) begin n_fail++; $display("FAIL snapclr_cycle: got %0d expected 9", d); end
    do_read(3'd4, v, d);
    n_checks++; if (d !== 4'd8) begin n_fail++; $display("FAIL snapclr_bad: got %0d expected 8", d); end
    pulse_snap;
    do_read(3'd1, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL snapclr_live_cleared: got %0d expected 0", d); end

    apply_reset;
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_stop_running: got %b expected 0", running); end
    tick; tick; tick;
    do_read(3'd6, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL start_stop_state: got %0d expected 0", d); end
    pulse_snap;
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL start_stop_cycle: got %0d expected 0", d); end
  endtask

  task automatic test_back_to_back;
    logic v; logic [W-1:0] d;
    int exp_v[3] = '{5, 3, 1};
    apply_reset;
    pulse_start;
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_snap;
    rd_req = 1'b1; rd_addr = 3'd0;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid: got %b expected 0", rd_valid); end
    for (int a = 0; a < 3; a++) begin
      tick;
      if (a < 2) rd_addr = 3'(a + 1); else rd_req = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'(exp_v[a])) begin
        n_fail++; $display("FAIL b2b_read%0d: got v=%b d=%0d expected v=1 d=%0d", a, rd_valid, rd_data, exp_v[a]);
      end
    end
    tick;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_trailing_valid: got %b expected 0", rd_valid); end
    do_read(3'd3, v, d);
    n_checks++; if (d !== 4'd2) begin n_fail++; $display("FAIL read_bp_ok: got %0d expected 2", d); end
    do_read(3'd6, v, d);
    n_checks++; if (d !== 4'd2) begin n_fail++; $display("FAIL read_state_halt: got %0d expected 2", d); end
    do_read(3'd7, v, d);
    n_checks++; if (v !== 1'b1 || d !== 4'd0) begin n_fail++; $display("FAIL read_addr7: got v=%b d=%0d expected v=1 d=0", v, d); end
    pulse_clear;
    snap = 1'b1;
    do_read(3'd0, v, d);
    snap = 1'b0;
    n_checks++; if (d !== 4'd5) begin n_fail++; $display("FAIL read_with_snap: got %0d expected 5", d); end
    do_read(3'd0, v, d);
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL read_after_snap: got %0d expected 0", d); end
  endtask

  task automatic test_reset_midrun;
    logic v; logic [W-1:0] d;
    apply_reset;
    pulse_start;
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    rd_req = 1'b1; rd_addr = 3'd6;
    tick;
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 4'd1) begin n_fail++; $display("FAIL midrun_pre_read: got v=%b d=%0d expected v=1 d=1", rd_valid, rd_data); end
    rd_addr = 3'd0;
    rstn = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 4'd0) begin n_fail++; $display("FAIL midrun_async_rd: got v=%b d=%0d expected v=0 d=0", rd_valid, rd_data); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL midrun_async_running: got %b expected 0", running); end
    tick;
    rstn = 1'b1; rd_req = 1'b0;
    tick;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_post_valid: got %b expected 0", rd_valid); end
    tick; tick;
    pulse_snap;
    for (int a = 0; a < 7; a++) begin
      do_read(3'(a), v, d);
      n_checks++;
      if (d !== 4'd0) begin n_fail++; $display("FAIL midrun_read%0d: got %0d expected 0", a, d); end
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; snap = 1'b0;
    ev_cond = 1'b0; ev_uncond = 1'b0; ev_bp_ok = 1'b0;
    rd_req = 1'b0; rd_addr = 3'd0;
    test_reset;
    test_basic_counting;
    test_gating;
    test_saturation;
    test_simultaneous;
    test_back_to_back;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
